// File: rtl/ysyx_22040931_idu_pkg.sv
// Shared decode constants: opcodes, funct3 values, aluop/exop codes and the
// immediate-format selector used by the decode-and-buffer stage.
package ysyx_22040931_idu_pkg;

   // Major opcodes handled by this stage
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   // funct3 values accepted for the I-type classes
   localparam logic [2:0] F3_JALR = 3'b000;
   localparam logic [2:0] F3_ADDI = 3'b000;

   // ALU operation codes (sized by the consumer's ALUOP_W)
   localparam int ALUOP_ADD = 0;
   localparam int ALUOP_LUI = 1;

   // Operand / extra-operation select codes (sized by the consumer's EXOP_W)
   localparam int EXOP_NO   = 0;
   localparam int EXOP_PC   = 1;
   localparam int EXOP_LINK = 2;

   // Which immediate layout the instruction carries
   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I    = 2'd1,
      IMM_U    = 2'd2,
      IMM_J    = 2'd3
   } imm_sel_e;

endpackage

// File: rtl/ysyx_22040931_idu_queue_dec.sv
// Pure combinational decoder: control bundle plus sign-extended immediate.
module ysyx_22040931_idu_dec
   import ysyx_22040931_idu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int ALUOP_W = 5,
   parameter int EXOP_W  = 3
) (
   input  logic [31:0]        inst,
   output logic [XLEN-1:0]    imm,
   output logic [4:0]         rd,
   output logic [4:0]         rs1,
   output logic [ALUOP_W-1:0] aluop,
   output logic [EXOP_W-1:0]  exop,
   output logic               utype,
   output logic               illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   imm_sel_e   imm_sel;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign rd     = inst[11:7];
   assign rs1    = inst[19:15];

   // Classify the opcode and pick control fields and immediate layout
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      aluop   = ALUOP_W'(ALUOP_ADD);
      exop    = EXOP_W'(EXOP_NO);
      utype   = 1'b0;
      illegal = 1'b0;
      imm_sel = IMM_NONE;
      case (opcode)
         OPC_LUI: begin
            aluop   = ALUOP_W'(ALUOP_LUI);
            utype   = 1'b1;
            imm_sel = IMM_U;
         end
         OPC_AUIPC: begin
            exop    = EXOP_W'(EXOP_PC);
            utype   = 1'b1;
            imm_sel = IMM_U;
         end
         OPC_JAL: begin
            exop    = EXOP_W'(EXOP_LINK);
            imm_sel = IMM_J;
         end
         OPC_JALR: begin
            if (funct3 == F3_JALR) begin
               exop    = EXOP_W'(EXOP_LINK);
               imm_sel = IMM_I;
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_OPIMM: begin
            if (funct3 == F3_ADDI) imm_sel = IMM_I;
            else                   illegal = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   // Assemble and sign-extend the immediate for the selected layout
   always_comb begin
      imm = '0;
      case (imm_sel)
         IMM_I: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
         IMM_U: imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
         IMM_J: imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                       inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_22040931_idu_queue.sv
// Decode-and-buffer stage: decodes each fetched beat and holds the result in
// a DEPTH-entry FIFO with valid/ready handshakes on both sides and a flush.
module ysyx_22040931_idu_queue
   import ysyx_22040931_idu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int DEPTH   = 2,
   parameter int ALUOP_W = 5,
   parameter int EXOP_W  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_inst,
   input  logic [XLEN-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_imm,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_rs1,
   output logic [ALUOP_W-1:0] out_aluop,
   output logic [EXOP_W-1:0]  out_exop,
   output logic               out_utype,
   output logic               out_illegal
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 2*XLEN + 10 + ALUOP_W + EXOP_W + 2;

   logic [XLEN-1:0]    dec_imm;
   logic [4:0]         dec_rd;
   logic [4:0]         dec_rs1;
   logic [ALUOP_W-1:0] dec_aluop;
   logic [EXOP_W-1:0]  dec_exop;
   logic               dec_utype;
   logic               dec_illegal;
   logic [ENTRY_W-1:0] dec_entry;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push, pop;

   ysyx_22040931_idu_dec #(
      .XLEN    (XLEN),
      .ALUOP_W (ALUOP_W),
      .EXOP_W  (EXOP_W)
   ) u_dec (
      .inst    (in_inst),
      .imm     (dec_imm),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .aluop   (dec_aluop),
      .exop    (dec_exop),
      .utype   (dec_utype),
      .illegal (dec_illegal)
   );

   assign dec_entry = {in_pc, dec_imm, dec_rd, dec_rs1, dec_aluop,
                       dec_exop, dec_utype, dec_illegal};

   // Handshake depends on registered state only (no out_ready -> in_ready path)
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   assign {out_pc, out_imm, out_rd, out_rs1, out_aluop,
           out_exop, out_utype, out_illegal} = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; flush wins over push/pop
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = dec_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is cleared too, so the out_* fields read as zero after reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
